data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h10010000, byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response valid; legal range 1..15.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  core presents a LW/SW request.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 req_write  input  1  1 = SW, 0 = LW.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  core consumes the response.
REQ-014 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 resp_error  output  1  misaligned or out-of-range access.

Function
REQ-016 SHALL implement states IDLE, WAIT, RESP.
REQ-017 IDLE: req_ready=1; req_valid=1 accepts request, captures write/addr/wdata, loads latency counter with LATENCY-1, goes to WAIT.
REQ-018 WAIT: req_ready=0; counter decrements each cycle; on counter==0 performs access and goes to RESP on the next edge, giving resp_valid exactly LATENCY cycles after the accepting edge.
REQ-019 RESP: resp_valid=1, outputs held stable until resp_ready=1; then returns to IDLE.
REQ-020 SHALL accept no new request while in WAIT or RESP; req_ready is 1 only in IDLE (no same-cycle RESP-to-accept overlap).
REQ-021 Word index SHALL be (req_addr - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic.
REQ-022 Error SHALL be flagged when req_addr[1:0] != 0, req_addr < BASE_ADDR, or index >= DEPTH_WORDS.
REQ-023 On error, store SHALL NOT modify memory; resp_rdata=0; resp_error=1.
REQ-024 Valid store SHALL write the word at the WAIT-to-RESP edge; resp_rdata=0, resp_error=0.
REQ-025 Valid load SHALL return the word stored at the WAIT-to-RESP edge.
REQ-026 A load following a store to the same address SHALL return the stored value.
REQ-027 Signal changes on req_* while not in IDLE SHALL have no effect.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_error=0, counter=0.
REQ-029 Reset during WAIT SHALL abort the pending access; a pending store SHALL NOT be committed.
REQ-030 Memory array contents SHALL NOT be cleared by reset; array initialises to all-zero at time 0.

Structure
REQ-031 State encoding, BASE_ADDR default and LATENCY width constants SHALL live in shared package mips_mem_pkg.
REQ-032 Storage SHALL be a separate sub-module data_mem_array (single write port, single combinational read port, indexed by word).
REQ-033 FSM, counter and address checks SHALL reside in data_mem_responder.

Verification
REQ-034 SW addr 32'h10010008 data 32'hDEADBEEF, then LW same addr -> each resp_valid 2 cycles after accept; LW returns 32'hDEADBEEF, resp_error=0.
REQ-035 LW addr 32'h10010006 -> resp_error=1, resp_rdata=0; SW 32'h10010400 data 32'h1 -> resp_error=1, later LW of word 255 unchanged.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata stay constant, req_ready=0; release -> IDLE next cycle.
REQ-037 Assert reset_n=0 one cycle after accepting SW 32'h10010000 data 32'h55 -> outputs cleared at once; subsequent LW returns 0.
REQ-038 LATENCY=1 and LATENCY=15 builds: back-to-back LW with resp_ready=1 -> response exactly 1 / 15 cycles after each accept.
REQ-039 LW addr 32'h1000FFFC (below base) -> resp_error=1; toggling req_addr during WAIT does not alter response.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data memory responder.
// Holds the FSM state encoding, default base address and counter width.
package mips_mem_pkg;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h1001_0000;
    localparam int          LAT_W         = 4;

    typedef logic [LAT_W-1:0] lat_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core (master) and the data memory.
// req_*: LW/SW request with valid/ready; resp_*: response with valid/ready.
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

endinterface

// File: rtl/data_mem_array.sv
// Word-indexed storage: one synchronous write port, one combinational read.
// Ports: clock, we/waddr/wdata (write), raddr/rdata (read). Not reset.
module data_mem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clock,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    // Power-up contents are zero; reset never touches the array.
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// LW/SW responder with fixed latency, address checking and error reporting.
// Ports: clock, reset_n (async, active-low), bus (slave side of the bus).
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          LATENCY     = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    data_mem_responder_if.slave bus
);

    localparam int IDX_W =
        (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam lat_cnt_t LAT_LOAD = lat_cnt_t'(LATENCY - 1);

    state_t      state, state_n;
    lat_cnt_t    cnt, cnt_n;
    logic        accept, access;
    logic        req_ready, resp_valid;

    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] rdata_q;
    logic        error_q;

    logic [31:0] offset, index;
    logic        addr_err;
    logic        mem_we;
    logic [31:0] mem_rdata;

    // Checks use the captured address so req_* may change during WAIT.
    assign offset   = cap_addr - BASE_ADDR;
    assign index    = offset >> 2;
    assign addr_err = (cap_addr[1:0] != 2'b00)
                   || (cap_addr < BASE_ADDR)
                   || (index >= 32'(DEPTH_WORDS));
    assign mem_we   = access && cap_write && !addr_err;

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .waddr (index[IDX_W-1:0]),
        .wdata (cap_wdata),
        .raddr (index[IDX_W-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        accept     = 1'b0;
        access     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_n   = LAT_LOAD;
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    access  = 1'b1;
                    state_n = ST_RESP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (bus.resp_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            if (accept) begin
                cap_write <= bus.req_write;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
            end
            if (access) begin
                rdata_q <= (!cap_write && !addr_err) ? mem_rdata : '0;
                error_q <= addr_err;
            end else if (resp_valid && bus.resp_ready) begin
                rdata_q <= '0;
                error_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = error_q;

endmodule
